// File: rtl/rca_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM encoding and nibble-count / index-width derivation.
package rca_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int unsigned NIB_BITS = 4;

  function automatic int unsigned nib_count(input int unsigned width);
    return width / NIB_BITS;
  endfunction

  // A single-nibble build still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/rca_serial_add_ctrl_if.sv
// Request/response bundle between a datapath and the serial adder sequencer.
// Signal suffixes are from the sequencer's (slave) point of view.
interface rca_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             c_in_i;
  logic             sub_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] s_o;
  logic             c_out_o;
  logic             ovf_o;

  modport master (
    output start_i, a_i, b_i, c_in_i, sub_i,
    input  busy_o, done_o, s_o, c_out_o, ovf_o
  );

  modport slave (
    input  start_i, a_i, b_i, c_in_i, sub_i,
    output busy_o, done_o, s_o, c_out_o, ovf_o
  );

endinterface

// File: rtl/rca_serial_add_ctrl_rca4.sv
// 4-bit ripple-carry adder: the single shared arithmetic element that the
// sequencer time-multiplexes across nibbles.
module Ripple_carry_adder_RCA_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic cy;

  always_comb begin
    s_o = '0;
    cy  = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ cy;
      cy     = (a_i[i] & b_i[i]) | (a_i[i] & cy) | (b_i[i] & cy);
    end
    c_o = cy;
  end

endmodule

// File: rtl/rca_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequencer: one nibble per clock through a shared
// 4-bit ripple-carry adder, LSB nibble first, inter-nibble carry registered.
module rca_serial_add_ctrl
  import rca_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  rca_serial_add_ctrl_if.slave bus_if
);

  localparam int unsigned NIB   = nib_count(WIDTH);
  localparam int unsigned IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   s_q;
  logic               c_out_q;
  logic               ovf_q;

  logic [3:0]         nib_a;
  logic [3:0]         nib_b;
  logic [3:0]         nib_sum;
  logic               nib_co;
  logic               last_nib;
  logic               busy;
  logic               done;

  assign nib_a    = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b    = b_q[{idx_q, 2'b00} +: 4];
  assign last_nib = (idx_q == IDX_LAST);

  Ripple_carry_adder_RCA_4bit u_rca4 (
    .a_i (nib_a),
    .b_i (nib_b),
    .c_i (carry_q),
    .s_o (nib_sum),
    .c_o (nib_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus_if.start_i) state_d = ST_RUN;
      ST_RUN:  if (last_nib)       state_d = ST_FIN;
      ST_FIN:                      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_FIN);
  end

  // B is stored already inverted for subtract so RUN never looks at SUB again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_if.start_i) begin
            a_q     <= bus_if.a_i;
            b_q     <= bus_if.sub_i ? ~bus_if.b_i : bus_if.b_i;
            carry_q <= bus_if.sub_i ? 1'b1 : bus_if.c_in_i;
            idx_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          s_q[{idx_q, 2'b00} +: 4] <= nib_sum;
          carry_q                  <= nib_co;
          if (last_nib) begin
            idx_q   <= '0;
            c_out_q <= nib_co;
            ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_if.busy_o  = busy;
  assign bus_if.done_o  = done;
  assign bus_if.s_o     = s_q;
  assign bus_if.c_out_o = c_out_q;
  assign bus_if.ovf_o   = ovf_q;

endmodule

// File: tb/tb_rca_serial_add_ctrl.sv
// Self-checking bench for rca_serial_add_ctrl: vector table plus hand-written
// sequences for re-pulsed START, held START and mid-run reset.
module tb_rca_serial_add_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rca_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  rca_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[9];

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h required 0x%h", nm, act, req);
    end
  endtask

  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c_in, input logic sub);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   full;
    be      = sub ? ~b : b;
    full    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : c_in)};
    e.s     = full[W-1:0];
    e.c_out = full[W];
    e.ovf   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard: every DONE pops one expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.done_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE=1 required no DONE");
      end else begin
        e = sb_q.pop_front();
        check("result_s", bus.s_o, e.s);
        check("result_c_out", W'(bus.c_out_o), W'(e.c_out));
        check("result_ovf", W'(bus.ovf_o), W'(e.ovf));
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 30; n++) begin
      if (!bus.busy_o && !bus.done_o) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got BUSY=%b DONE=%b required idle", bus.busy_o, bus.done_o);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c_in, input logic sub, input logic start);
    bus.a_i     = a;
    bus.b_i     = b;
    bus.c_in_i  = c_in;
    bus.sub_i   = sub;
    bus.start_i = start;
  endtask

  // One operation with latency/busy/hold checks; repulse re-asserts START mid-RUN.
  task automatic run_op(input vec_t v, input bit repulse);
    exp_t e;
    int   edges;
    int   busy_cnt;
    bit   got;
    wait_idle();
    @(negedge clk);
    drive(v.a, v.b, v.c_in, v.sub, 1'b1);
    e.s = v.s; e.c_out = v.c_out; e.ovf = v.ovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    drive(W'($urandom), W'($urandom), 1'b1, ~v.sub, 1'b0);
    edges    = 1;
    busy_cnt = 0;
    got      = 0;
    while (!got && edges < 20) begin
      if (bus.done_o) begin
        got = 1;
      end else begin
        if (bus.busy_o) busy_cnt++;
        if (repulse && edges == 2) drive(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1);
        if (repulse && edges == 3) bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        edges++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE after %0d edges required DONE", edges);
      return;
    end
    check("latency_edges", W'(edges), W'(NIB + 1));
    check("busy_cycles", W'(busy_cnt), W'(NIB));
    check("busy_at_done", W'(bus.busy_o), W'(0));
    @(posedge clk);
    #1;
    check("done_one_cycle", W'(bus.done_o), W'(0));
    check("s_hold", bus.s_o, v.s);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    exp_t e;
    int   last_done;
    bit   got;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    drive('0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    check("rst_busy", W'(bus.busy_o), W'(0));
    check("rst_done", W'(bus.done_o), W'(0));
    check("rst_s", bus.s_o, W'(0));
    check("rst_c_out", W'(bus.c_out_o), W'(0));
    check("rst_ovf", W'(bus.ovf_o), W'(0));
    #10 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i], 1'b0);

    run_op(vecs[0], 1'b1);

    // Reset after two RUN edges: outputs clear at once and no DONE follows.
    wait_idle();
    @(negedge clk);
    drive(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", W'(bus.busy_o), W'(0));
    check("mid_rst_done", W'(bus.done_o), W'(0));
    check("mid_rst_s", bus.s_o, W'(0));
    check("mid_rst_c_out", W'(bus.c_out_o), W'(0));
    check("mid_rst_ovf", W'(bus.ovf_o), W'(0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(vecs[8], 1'b0);

    // START held high: one result every NIB+2 cycles, operands changed between ops.
    wait_idle();
    @(negedge clk);
    drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    sb_q.push_back(ref_op(bus.a_i, bus.b_i, bus.c_in_i, bus.sub_i));
    last_done = -1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (bus.done_o) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL held_timeout: got no DONE for op %0d required DONE", k);
        break;
      end
      if (last_done >= 0) check("held_period", W'(cyc - last_done), W'(NIB + 2));
      last_done = cyc;
      if (k < 3) begin
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        e = ref_op(bus.a_i, bus.b_i, bus.c_in_i, bus.sub_i);
        sb_q.push_back(e);
      end else begin
        bus.start_i = 1'b0;
      end
    end

    repeat (NIB + 4) @(posedge clk);
    #1;
    check("sb_drain", W'(sb_q.size()), W'(0));
    check("end_idle", W'(bus.busy_o), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
